// File: rtl/pri_encoder_drain.sv
// pri_encoder_drain: registered priority encoder that drains a request vector.
// A nonzero vector is captured into a pending register, and its set bits are
// emitted one index per output handshake, in priority order. Each emitted bit
// is cleared from the pending register. An all-zero vector is absorbed and
// signalled with a single-cycle zero_pulse.
// Optional build macro PRI_ENCODER_DRAIN_COUNT_EN adds out_cnt, which is the
// population count of the pending register.
module pri_encoder_drain #(
    parameter int WIDTH     = 16,
    parameter int IDX_W     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             zero_pulse,
`ifdef PRI_ENCODER_DRAIN_COUNT_EN
    output logic [IDX_W:0]   out_cnt,
`endif
    output logic             busy
);

    // Reject parameter sets that could produce an index that does not fit
    generate
        if (WIDTH < 2 || (1 << IDX_W) < WIDTH) begin : g_bad_params
            $error("pri_encoder_drain: need WIDTH >= 2 and 2**IDX_W >= WIDTH");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_pending;
    logic               r_zero;
    logic [IDX_W-1:0]   w_idx;
    logic [WIDTH-1:0]   w_onehot;
    logic               w_multi;
    logic               w_last;
    logic               w_load;
    logic               w_zero;
    logic               w_pop;

    // Select the winning pending bit. The loop direction makes the
    // highest-priority bit the last one assigned.
    always_comb begin
        w_idx    = '0;
        w_onehot = '0;
        if (LSB_FIRST) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (r_pending[i]) begin
                    w_idx       = IDX_W'(i);
                    w_onehot    = '0;
                    w_onehot[i] = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_pending[i]) begin
                    w_idx       = IDX_W'(i);
                    w_onehot    = '0;
                    w_onehot[i] = 1'b1;
                end
            end
        end
    end

    // Exactly one bit is set when clearing the lowest set bit leaves nothing
    always_comb begin
        w_multi = |(r_pending & (r_pending - WIDTH'(1)));
        w_last  = (|r_pending) && !w_multi;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and handshake decode. A vector is accepted only in IDLE,
    // so a new vector can never land on the cycle of the final output.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_load      = 1'b0;
        w_zero      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (|in_vec) begin
                        w_load      = 1'b1;
                        w_state_nxt = DRAIN;
                    end else begin
                        w_zero = 1'b1;
                    end
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_pop = 1'b1;
                    if (w_last) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Pending register: load on accept, and clear the emitted bit on each pop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else if (w_load) begin
            r_pending <= in_vec;
        end else if (w_pop) begin
            r_pending <= r_pending & ~w_onehot;
        end
    end

    // Single-cycle flag for an accepted all-zero vector
    always_ff @(posedge clk) begin
        if (reset) begin
            r_zero <= 1'b0;
        end else begin
            r_zero <= w_zero;
        end
    end

    assign out_idx    = w_idx;
    assign out_last   = w_last;
    assign zero_pulse = r_zero;

`ifdef PRI_ENCODER_DRAIN_COUNT_EN
    localparam int CNT_W = IDX_W + 1;
    logic [CNT_W-1:0] w_cnt;

    // Population count of the pending bits, including the current index
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt = w_cnt + CNT_W'(r_pending[i]);
        end
    end

    assign out_cnt = w_cnt;
`endif

endmodule
